// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink: programmable tready backpressure, continuous data-counter check,
// packet-length/tlast check, saturating stats. Optional stall timeout: AXIS_PKT_CHK_TIMEOUT_EN.
module axis_pkt_checker #(
    parameter int DW      = 8,
    parameter int MAX_LEN = 2048,
    parameter int LW      = $clog2(MAX_LEN + 1),
    parameter int CW      = 16
`ifdef AXIS_PKT_CHK_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    input  logic          enable,
    input  logic          clr,
    input  logic [LW-1:0] cfg_len,
    input  logic [3:0]    cfg_ready_mask,
    output logic [CW-1:0] pkt_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_data,
    output logic          err_len,
    output logic          pkt_done,
    output logic          busy
`ifdef AXIS_PKT_CHK_TIMEOUT_EN
    ,
    output logic          err_timeout
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state;
    logic [1:0]    phase;
    logic [LW-1:0] idx, len, len_cfg, idx_inc;
    logic [DW-1:0] exp;
    logic          accept, chk_beat, len_hit, end_pkt, abort;

    assign busy     = (state != IDLE);
    assign s_tready = busy & cfg_ready_mask[phase];
    assign accept   = s_tvalid & s_tready;
    assign chk_beat = accept & (state == RECV);
    assign idx_inc  = idx + 1'b1;
    assign len_hit  = (idx_inc == len);
    // Any accepted tlast closes the packet, whether on time, early, or after a drain.
    assign end_pkt  = accept & s_tlast;
    assign len_cfg  = (cfg_len == '0) ? LW'(MAX_LEN) : cfg_len;

`ifdef AXIS_PKT_CHK_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_cnt;
    logic          stall;

    assign stall = s_tready & ~s_tvalid & ((idx != '0) | (state == DRAIN));
    assign abort = stall & (stall_cnt == SW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (accept || !busy || abort) stall_cnt <= '0;
            else if (stall)               stall_cnt <= stall_cnt + 1'b1;
            if (clr)        err_timeout <= 1'b0;
            else if (abort) err_timeout <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            phase    <= '0;
            idx      <= '0;
            len      <= '0;
            exp      <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= end_pkt;
            // exp follows the observed data so one bad beat costs exactly one error.
            if (chk_beat) exp <= s_tdata + 1'b1;
            if (abort) begin
                state <= IDLE;
                phase <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        phase <= '0;
                        if (enable) begin
                            state <= RECV;
                            len   <= len_cfg;
                            idx   <= '0;
                        end
                    end
                    RECV, DRAIN: begin
                        if (end_pkt) begin
                            state <= enable ? RECV : IDLE;
                            phase <= enable ? phase + 2'd1 : 2'd0;
                            idx   <= '0;
                            len   <= len_cfg;
                        end else begin
                            phase <= phase + 2'd1;
                            if (chk_beat) begin
                                if (len_hit) state <= DRAIN;
                                else         idx   <= idx_inc;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_data <= 1'b0;
            err_len  <= 1'b0;
        end else if (clr) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_data <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            if (end_pkt && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            if (chk_beat && s_tdata != exp) begin
                err_data <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            // Early tlast and missing tlast are both a mismatch between tlast and the count.
            if (chk_beat && (s_tlast != len_hit)) err_len <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Bench for axis_pkt_checker: directed packets against a per-cycle reference model,
// plus a CW=2 instance sharing the stimulus to exercise counter saturation.
module tb_axis_pkt_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, enable, clr;
    logic [11:0] cfg_len;
    logic [3:0]  cfg_ready_mask;

    logic        s_tready, err_data, err_len, pkt_done, busy;
    logic [15:0] pkt_cnt, err_cnt;
    logic        q_tready, q_err_data, q_err_len, q_pkt_done, q_busy;
    logic [1:0]  q_pkt_cnt, q_err_cnt;

    int n_chk = 0, n_fail = 0, n_done = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    axis_pkt_checker u_dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .enable(enable), .clr(clr), .cfg_len(cfg_len),
        .cfg_ready_mask(cfg_ready_mask), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
        .err_data(err_data), .err_len(err_len), .pkt_done(pkt_done), .busy(busy));

    axis_pkt_checker #(.CW(2)) u_sat (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(q_tready), .enable(enable), .clr(clr), .cfg_len(cfg_len),
        .cfg_ready_mask(cfg_ready_mask), .pkt_cnt(q_pkt_cnt), .err_cnt(q_err_cnt),
        .err_data(q_err_data), .err_len(q_err_len), .pkt_done(q_pkt_done), .busy(q_busy));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: packet-level bookkeeping. mode 0 = waiting to start, 1 = counting beats,
    // 2 = length reached, swallowing beats until tlast.
    int m_mode = 0, m_ph = 0, m_beats = 0, m_len = 0, m_exp = 0;
    int m_pkt = 0, m_err = 0, m_ed = 0, m_el = 0, m_done = 0;

    always @(posedge clk or negedge rst) begin
        int nmode;
        bit took, fin;
        if (!rst) begin
            m_mode = 0; m_ph = 0; m_beats = 0; m_len = 0; m_exp = 0;
            m_pkt = 0; m_err = 0; m_ed = 0; m_el = 0; m_done = 0;
        end else begin
            took  = (m_mode != 0) && cfg_ready_mask[m_ph] && s_tvalid;
            fin   = took && s_tlast;
            nmode = m_mode;
            if (m_mode == 0 && enable) begin
                m_len = (cfg_len == 0) ? 2048 : int'(cfg_len);
                m_beats = 0;
                nmode = 1;
            end
            if (m_mode == 1 && took) begin
                if (!clr && int'(s_tdata) != m_exp) begin
                    m_ed = 1;
                    if (m_err < 65535) m_err++;
                end
                m_exp = (int'(s_tdata) + 1) % 256;
                m_beats++;
                if (!clr && (s_tlast != (m_beats == m_len))) m_el = 1;
                if (!s_tlast && m_beats == m_len) nmode = 2;
            end
            if (fin) begin
                if (!clr && m_pkt < 65535) m_pkt++;
                m_beats = 0;
                m_len = (cfg_len == 0) ? 2048 : int'(cfg_len);
                nmode = enable ? 1 : 0;
            end
            if (clr) begin m_pkt = 0; m_err = 0; m_ed = 0; m_el = 0; end
            m_ph   = (nmode == 0 || m_mode == 0) ? 0 : (m_ph + 1) % 4;
            m_mode = nmode;
            m_done = fin;
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            if (pkt_done) n_done++;
            chk("s_tready", s_tready, (m_mode != 0) && cfg_ready_mask[m_ph]);
            chk("busy", busy, m_mode != 0);
            chk("pkt_done", pkt_done, m_done);
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("err_cnt", err_cnt, m_err);
            chk("err_data", err_data, m_ed);
            chk("err_len", err_len, m_el);
            chk("sat_pkt_cnt", q_pkt_cnt, (m_pkt > 3) ? 3 : m_pkt);
            chk("sat_err_cnt", q_err_cnt, (m_err > 3) ? 3 : m_err);
        end
    end

    // Called at a falling edge; holds the beat until a rising edge sees ready.
    task automatic send(input int d, input bit l);
        int  n = 0;
        bit  got = 0;
        s_tdata  = 8'(d);
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!got && n < 50) begin
            #1;
            got = s_tready;
            @(negedge clk);
            n++;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake: beat %0d not accepted within 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_sec(input int len, input logic [3:0] mask);
        cfg_len        = 12'(len);
        cfg_ready_mask = mask;
        enable         = 1'b1;
    endtask

    initial begin
        int dat [4];
        rst = 1'b1; enable = 1'b0; clr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; cfg_len = 12'd4; cfg_ready_mask = 4'hF;
        #1 rst = 1'b0;

        // reset / idle
        @(negedge clk);
        chk_on = 1;
        repeat (2) @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tready", s_tready, 0);
        chk("idle_busy", busy, 0);

        // nominal: three 4-beat packets, data 0..11
        begin_sec(4, 4'hF);
        for (int i = 0; i < 12; i++) begin
            if (i == 11) enable = 1'b0;
            send(i, (i % 4) == 3);
        end
        idle(3);
        chk("nom_pkt_cnt", pkt_cnt, 3);
        chk("nom_done_pulses", n_done, 3);
        chk("nom_err_cnt", err_cnt, 0);
        chk("nom_flags", {err_data, err_len}, 0);

        // backpressure: ready every other cycle, two 8-beat packets, data 12..27
        begin_sec(8, 4'b0101);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) enable = 1'b0;
            send(12 + i, (i % 8) == 7);
        end
        idle(3);
        chk("bp_pkt_cnt", pkt_cnt, 5);
        chk("bp_err_cnt", err_cnt, 0);

        // data error: expected 28,29,30,31 ; 37 is wrong, 38 then matches the resynced counter
        begin_sec(4, 4'hF);
        dat = '{28, 29, 37, 38};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) enable = 1'b0;
            send(dat[i], i == 3);
        end
        idle(3);
        chk("de_err_cnt", err_cnt, 1);
        chk("de_err_data", err_data, 1);
        chk("de_err_len", err_len, 0);
        chk("de_pkt_cnt", pkt_cnt, 6);

        // early tlast on beat 2
        begin_sec(4, 4'hF);
        send(39, 0);
        send(40, 1);
        chk("early_err_len", err_len, 1);
        chk("early_pkt_cnt", pkt_cnt, 7);
        // missing tlast: 6 beats, beats 5-6 drained, clr lands with the packet end
        for (int i = 0; i < 5; i++) send(41 + i, 0);
        chk("drain_busy", busy, 1);
        chk("drain_pkt_cnt", pkt_cnt, 7);
        enable = 1'b0;
        clr    = 1'b1;
        send(46, 1);
        clr    = 1'b0;
        idle(3);
        chk("clr_pkt_cnt", pkt_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_flags", {err_data, err_len}, 0);

        // cfg_len = 0 means 2048 beats; drain did not advance exp, so data resumes at 45
        begin_sec(0, 4'hF);
        for (int i = 0; i < 2048; i++) begin
            if (i == 2047) enable = 1'b0;
            send((45 + i) % 256, i == 2047);
        end
        idle(3);
        chk("max_pkt_cnt", pkt_cnt, 1);
        chk("max_err_cnt", err_cnt, 0);
        chk("max_err_len", err_len, 0);

        // five more packets: narrow counter holds at all-ones
        begin_sec(4, 4'hF);
        for (int i = 0; i < 20; i++) begin
            if (i == 19) enable = 1'b0;
            send(45 + i, (i % 4) == 3);
        end
        idle(3);
        chk("sat_pkt_cnt_end", q_pkt_cnt, 3);
        chk("wide_pkt_cnt_end", pkt_cnt, 6);

        // reset mid-packet: partial packet dropped, restart idle
        begin_sec(4, 4'hF);
        send(65, 0);
        send(66, 0);
        s_tvalid = 1'b0;
        enable   = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        rst = 1'b1;
        idle(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tready", s_tready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- AXI-Stream sink that terminates the master side of a stream FIFO.
- Drives a programmable tready pattern to create backpressure.
- Checks each beat's data against a running expected counter and checks that tlast falls at the configured packet length.
- Keeps saturating packet and error counters plus sticky error flags; used as the standard consumer in stream block benches and on-chip loopback.

Parameters:
DW, 8, stream data width.
MAX_LEN, 2048, maximum packet length in beats.
LW, $clog2(MAX_LEN+1), width of the length fields.
CW, 16, width of the statistic counters.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous reset, active-low.
s_tdata  input  DW  stream data.
s_tvalid  input  1  stream valid.
s_tlast  input  1  last beat of packet.
s_tready  output  1  stream ready.
enable  input  1  checker run request.
clr  input  1  synchronous clear of counters and flags.
cfg_len  input  LW  expected beats per packet; 0 means MAX_LEN.
cfg_ready_mask  input  4  tready pattern, indexed by the phase counter.
pkt_cnt  output  CW  good-or-bad packets completed (saturating).
err_cnt  output  CW  data mismatches (saturating).
err_data  output  1  sticky flag: data mismatch seen.
err_len  output  1  sticky flag: length or tlast error seen.
pkt_done  output  1  one-cycle pulse at packet end.
busy  output  1  high when not in IDLE.

Behaviour:
- Reset: rst low asynchronously forces every output, the FSM, phase, beat index and expected value to 0.
- Reset released mid-packet: the checker restarts in IDLE and the partial packet is not counted.
- Accepted beat: a cycle with s_tvalid and s_tready both high.
- s_tready = (state is RECV or DRAIN) AND cfg_ready_mask[phase].
- phase: 2-bit counter that increments every cycle while busy and holds at 0 in IDLE.
- s_tready does not depend combinationally on s_tvalid.
- FSM IDLE: when enable is high, latch len = (cfg_len==0 ? MAX_LEN : cfg_len), set idx=0, go to RECV next cycle.
- FSM RECV, on an accepted beat:
  - If s_tdata != exp, set err_data and increment err_cnt.
  - In all cases exp <= s_tdata+1 (mod 2^DW), so the checker resyncs to the observed data.
  - If s_tlast and idx+1 == len: packet end.
  - If s_tlast and idx+1 < len: set err_len; packet end (early tlast).
  - If !s_tlast and idx+1 == len: set err_len; go to DRAIN (missing tlast).
  - Otherwise idx++.
- FSM DRAIN: accept beats without checking data or advancing exp, until a beat with s_tlast; that beat is the packet end.
- Packet end (same edge as the final accepted beat):
  - pkt_done pulses for exactly one cycle and pkt_cnt increments.
  - idx=0 and len is re-latched from cfg_len.
  - Next state is RECV if enable is still high, else IDLE.
- enable deasserted mid-packet: the current packet completes before the FSM returns to IDLE.
- exp is not reset between packets: data is checked as one continuous stream.
- Counters saturate at all-ones.
- clr: zeroes pkt_cnt, err_cnt, err_data and err_len on the next edge. clr wins over a simultaneous increment or flag set. clr has no effect on FSM, idx or exp.
- Latency: all outputs are registered; errors and pkt_done are visible the cycle after the causing accepted beat.

Optional Feature:
Macro AXIS_PKT_CHK_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT (default 256) and output err_timeout (1-bit, sticky).
  - A stall counter runs in RECV/DRAIN while s_tready is high and s_tvalid is low, with idx>0 or in DRAIN; any accepted beat clears it.
  - When the counter reaches TIMEOUT: set err_timeout, return to IDLE, do not count the packet.
  - clr clears err_timeout.
- Not defined: no port, no counter; a mid-packet stall waits indefinitely.

Test Plan:
- Reset/idle: hold rst low 3 cycles, enable=0 -> all outputs 0, s_tready=0; after release, still 0 while enable=0.
- Nominal: cfg_len=4, mask=4'hF, 3 packets of data 0..11 with tlast on beats 4/8/12 -> pkt_done pulses 3 times, pkt_cnt=3, err_cnt=0, flags 0.
- Backpressure: mask=4'b0101, source holds data while not ready, 2 packets of len 8 -> s_tready alternates every cycle, no beat lost, pkt_cnt=2, no errors.
- Data error: len 4, data 0,1,9,10 -> err_cnt=1 (the 9), err_data=1, and 10 is accepted without error.
- Length errors: cfg_len=4.
  - Case 1: tlast on beat 2 -> err_len=1, pkt_cnt=1.
  - Case 2: next packet of 6 beats with tlast on beat 6 -> err_len, DRAIN absorbs beats 5-6, pkt_cnt=2.
  - Then clr together with a packet end -> pkt_cnt=0, all flags 0.
- Zero length/saturation: cfg_len=0, continuous 2048-beat packet with tlast on beat 2048 -> no errors. Force pkt_cnt via CW=2 build with 5 packets -> pkt_cnt holds at 3.
